// File: rtl/fast_corner_collector.sv
// ---------------------------------------------------------------------------
// fast_corner_collector
//
// Collects the corner flags produced by the FAST+NMS stage. Each accepted
// corner is packed into a coordinate word and queued in a show-ahead FIFO.
// Every frame is closed with one trailer word that carries the corner count
// and a drop flag. The FAST stage cannot be stalled, so a corner that finds
// no space is dropped and flagged rather than back-pressured.
//
// Ports
//   clk        : clock
//   rst        : asynchronous reset, active-low
//   in_valid   : pixel inputs valid this cycle
//   iscorner   : corner flag for (x_coord, y_coord)
//   x_coord    : column of the current pixel
//   y_coord    : row of the current pixel
//   m_valid    : output word valid
//   m_ready    : downstream accepts the word
//   m_data     : corner word {0, y, x} or trailer {1, drop, 0.., count[18:0]}
//   m_last     : m_data is a trailer
//   frame_cnt  : trailers written since reset (wraps)
//   fifo_level : FIFO occupancy after the most recent edge
// ---------------------------------------------------------------------------
module fast_corner_collector #(
    parameter int COL_NUM     = 640,
    parameter int ROW_NUM     = 480,
    parameter int COORD_W     = 10,
    parameter int FIFO_DEPTH  = 64,
    parameter int MAX_CORNERS = 2048
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    input  logic                          iscorner,
    input  logic [COORD_W-1:0]            x_coord,
    input  logic [COORD_W-1:0]            y_coord,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic [2*COORD_W:0]            m_data,
    output logic                          m_last,
    output logic [15:0]                   frame_cnt,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int DW    = 2*COORD_W + 1;
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int LW    = AW + 1;
    localparam int CNT_W = 19;

    localparam logic [COORD_W-1:0] X_LAST       = COORD_W'(COL_NUM - 1);
    localparam logic [COORD_W-1:0] Y_LAST       = COORD_W'(ROW_NUM - 1);
    localparam logic [LW-1:0]      CORNER_ROOM  = LW'(FIFO_DEPTH - 2);
    localparam logic [LW-1:0]      TRAILER_ROOM = LW'(FIFO_DEPTH - 1);
    localparam logic [CNT_W-1:0]   CAP          = CNT_W'(MAX_CORNERS);

    typedef enum logic [1:0] {
        S_SYNC,
        S_RUN,
        S_TRL
    } state_t;

    logic               r_inValid;
    logic               r_isCorner;
    logic [COORD_W-1:0] r_x;
    logic [COORD_W-1:0] r_y;

    state_t             r_state;
    state_t             w_nextState;
    logic [CNT_W-1:0]   r_count;
    logic [CNT_W-1:0]   w_nextCount;
    logic               r_drop;
    logic               w_nextDrop;
    logic [15:0]        r_frameCnt;
    logic               w_frameInc;

    logic [DW-1:0]      r_mem [FIFO_DEPTH];
    logic [AW-1:0]      r_wrPtr;
    logic [AW-1:0]      r_rdPtr;
    logic [LW-1:0]      r_level;

    logic               w_start;
    logic               w_end;
    logic               w_corner;
    logic               w_process;
    logic               w_wrEn;
    logic [DW-1:0]      w_wrData;
    logic [DW-1:0]      w_trailer;
    logic               w_mValid;
    logic               w_rdEn;

    // Pixel inputs are registered first; the FSM works on the registered copy
    // so a corner reaches the FIFO one edge after it was captured.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_inValid  <= 1'b0;
            r_isCorner <= 1'b0;
            r_x        <= '0;
            r_y        <= '0;
        end else begin
            r_inValid  <= in_valid;
            r_isCorner <= iscorner;
            r_x        <= x_coord;
            r_y        <= y_coord;
        end
    end

    assign w_start   = r_inValid && (r_x == '0) && (r_y == '0);
    assign w_end     = r_inValid && (r_x == X_LAST) && (r_y == Y_LAST);
    assign w_corner  = r_inValid && r_isCorner;
    // A start pixel seen while resynchronising is handled exactly like RUN.
    assign w_process = (r_state == S_RUN) || ((r_state == S_SYNC) && w_start);

    // Trailer: MSB set, drop flag just below it, count in the low 19 bits.
    always_comb begin
        w_trailer              = '0;
        w_trailer[DW-1]        = 1'b1;
        w_trailer[DW-2]        = r_drop;
        w_trailer[CNT_W-1:0]   = r_count;
    end

    // Next-state and write decision. Corners keep one slot in reserve so the
    // trailer always has room; the trailer only needs a single free slot.
    always_comb begin
        w_nextState = r_state;
        w_nextCount = r_count;
        w_nextDrop  = r_drop;
        w_frameInc  = 1'b0;
        w_wrEn      = 1'b0;
        w_wrData    = '0;

        if (w_process) begin
            if (w_corner) begin
                if ((r_count < CAP) && (r_level <= CORNER_ROOM)) begin
                    w_wrEn      = 1'b1;
                    w_wrData    = {1'b0, r_y, r_x};
                    w_nextCount = r_count + CNT_W'(1);
                end else begin
                    w_nextDrop = 1'b1;
                end
            end
            w_nextState = w_end ? S_TRL : S_RUN;
        end

        // The trailer owns the write port, so a corner arriving now is lost
        // and charged to the frame that is just starting.
        if (r_state == S_TRL) begin
            w_wrEn      = (r_level <= TRAILER_ROOM);
            w_wrData    = w_trailer;
            w_frameInc  = 1'b1;
            w_nextCount = '0;
            w_nextDrop  = w_corner;
            w_nextState = w_start ? S_RUN : S_SYNC;
        end
    end

    // Frame bookkeeping: state, per-frame counters and the frame counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_SYNC;
            r_count    <= '0;
            r_drop     <= 1'b0;
            r_frameCnt <= '0;
        end else begin
            r_state    <= w_nextState;
            r_count    <= w_nextCount;
            r_drop     <= w_nextDrop;
            r_frameCnt <= r_frameCnt + 16'(w_frameInc);
        end
    end

    // Show-ahead FIFO. There is no bypass: a read only pops a word that was
    // already present before this edge.
    assign w_mValid = (r_level != '0);
    assign w_rdEn   = w_mValid && m_ready;

    always_ff @(posedge clk) begin
        if (w_wrEn) begin
            r_mem[r_wrPtr] <= w_wrData;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_level <= '0;
        end else begin
            if (w_wrEn) begin
                r_wrPtr <= r_wrPtr + AW'(1);
            end
            if (w_rdEn) begin
                r_rdPtr <= r_rdPtr + AW'(1);
            end
            r_level <= r_level + LW'(w_wrEn) - LW'(w_rdEn);
        end
    end

    assign m_valid    = w_mValid;
    assign m_data     = w_mValid ? r_mem[r_rdPtr] : '0;
    assign m_last     = w_mValid && m_data[DW-1];
    assign frame_cnt  = r_frameCnt;
    assign fifo_level = r_level;

endmodule

// File: doc/fast_corner_collector.md
Name: fast_corner_collector

Overview:
- Consumes the per-pixel corner stream (`iscorner`, `x_coord`, `y_coord`) produced by the FAST+NMS stage.
- Packs each accepted corner into a coordinate word and buffers the words in an internal FIFO.
- Closes every frame with one trailer word carrying the corner count and a drop flag.
- Presents words on a valid/ready stream to the downstream descriptor/DMA stage. The FAST stage cannot be stalled, so corners that find no buffer space are dropped and flagged, never back-pressured.

Parameters:
- COL_NUM, 640, image width in pixels.
- ROW_NUM, 480, image height in pixels.
- COORD_W, 10, coordinate width; must satisfy 2^COORD_W >= max(COL_NUM, ROW_NUM).
- FIFO_DEPTH, 64, word slots; power of 2, >= 4.
- MAX_CORNERS, 2048, per-frame cap on accepted corners; < 2^19.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-low (asserted when 0).
- in_valid  in  1  coordinate/flag inputs valid this cycle (FAST stage ce-aligned).
- iscorner  in  1  corner flag for (x_coord, y_coord).
- x_coord  in  COORD_W  column of current pixel.
- y_coord  in  COORD_W  row of current pixel.
- m_valid  out  1  output word valid.
- m_ready  in  1  downstream accepts word.
- m_data  out  2*COORD_W+1  output word.
- m_last  out  1  high when m_data is a trailer.
- frame_cnt  out  16  trailers written since reset; wraps.
- fifo_level  out  clog2(FIFO_DEPTH)+1  FIFO occupancy.

Behaviour:
- Reset (rst=0, async): FSM to SYNC; FIFO emptied; counters and flags cleared; m_valid=0, m_data=0, m_last=0, frame_cnt=0, fifo_level=0.
- Word formats:
  - Corner word: MSB=0, then y_coord, then x_coord (LSBs).
  - Trailer word: MSB=1; bit[2*COORD_W-1]=drop flag; low 19 bits = accepted corner count; other bits 0.
- Start pixel is in_valid && x=0 && y=0. End pixel is in_valid && x=COL_NUM-1 && y=ROW_NUM-1.
- FSM:
  - SYNC: all corners ignored (no count, no drop flag). On a start pixel go to RUN and process that pixel as RUN. Resynchronises after reset or a mid-frame reset.
  - RUN: on in_valid && iscorner, the corner is accepted if count < MAX_CORNERS and fifo_level <= FIFO_DEPTH-2. Otherwise it is dropped and the drop flag is set. On the end pixel, process its corner as above, then go to TRL.
  - TRL (exactly one cycle): write the trailer using that frame's count and flag. Increment frame_cnt. Clear count and flag. A corner arriving this cycle is dropped and sets the new frame's drop flag. If this cycle carries a start pixel, go to RUN; otherwise go to SYNC.
- Reserving one slot for corners guarantees the trailer is never lost; a trailer write needs only fifo_level <= FIFO_DEPTH-1.
- Latency: inputs are registered at edge E and written to the FIFO at edge E+1. The FIFO is show-ahead, so with an empty FIFO m_valid rises after edge E+1.
- Output handshake:
  - A word transfers on m_valid && m_ready.
  - m_data and m_last hold stable while m_valid && !m_ready.
  - m_valid never drops without a transfer.
- Same-cycle write and read: both occur; fifo_level is unchanged. A write with fifo_level=0 alongside a read is legal only if the read pops an already-present word; no bypass path exists.
- Pointers wrap modulo FIFO_DEPTH. fifo_level reflects the state after the edge.
- in_valid=0 cycles are ignored in every state.

Test Plan:
- Reset release, start pixel (0,0), corners at (5,3) and (100,200), end pixel at (639,479), m_ready=1 -> words {0,3,5}, {0,200,100}, then trailer with count=2 and drop=0, m_last=1 only on the trailer; frame_cnt=1; first m_valid one cycle after the (5,3) capture edge.
- m_ready=0 for a whole frame with 70 corners, FIFO_DEPTH=64 -> 63 corners accepted, trailer count=63, drop=1, fifo_level=64. Then m_ready=1 -> 64 words drain in order and m_data stays stable across stall cycles.
- MAX_CORNERS=4, frame with 6 corners, m_ready=1 -> 4 corner words, trailer count=4, drop=1.
- Reset asserted mid-frame at (300,100), released at (400,100), corners before the next (0,0) -> no output, fifo_level=0. The next full frame produces a normal trailer with frame_cnt=1.
- Back-to-back frames with the start pixel arriving on the TRL cycle and carrying a corner -> FSM goes to RUN with no SYNC gap; the second frame's trailer has drop=1.
- Random m_ready toggling over 3 frames -> output sequence matches a reference model word for word, with no loss or duplication.
